// File: rtl/piso_readout_pkg.sv
// piso_readout_pkg
//   Shared definitions for the parallel-in / serial-out readout path.
//   The state encoding is exported so the matching sample-side logic can
//   decode the transmitter state with identical values.
//
//   Contents:
//     piso_state_t  -- FSM state encoding (IDLE=0, SHIFT=1, PAR=2, FIN=3)
//     STATE_W       -- width of the encoded state
package piso_readout_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } piso_state_t;

endpackage

// File: rtl/piso_readout_stacked.sv
// piso_readout_stacked
//   Parallel-in / serial-out readout serializer. A word accepted in IDLE is
//   sent MSB first, one bit per SHIFT_EN, followed by a one-cycle DONE pulse.
//
//   Build option: define PISO_READOUT_PARITY_EN to append an even-parity bit
//   (state PAR) after the last data bit. Without it the frame is exactly
//   WIDTH bits and no parity state or register exists.
//
//   Parameters:
//     WIDTH        data bits per frame, 2..32
//   Ports:
//     CLK          clock, rising edge
//     RST          asynchronous active-high reset
//     LOAD_VALID   DATA_IN offered for transmission
//     LOAD_READY   high only in IDLE; accept = LOAD_VALID && LOAD_READY
//     DATA_IN      parallel word to serialize
//     SHIFT_EN     consume the current serial bit this cycle
//     SHIFT_OUT    current serial bit (0 when not transmitting)
//     SHIFT_VALID  SHIFT_OUT carries a frame bit
//     DONE         single-cycle pulse after the last bit is consumed
module piso_readout_stacked
  import piso_readout_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             SHIFT_EN,
  output logic             SHIFT_OUT,
  output logic             SHIFT_VALID,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);

  piso_state_t      state_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] cnt_reg;
`ifdef PISO_READOUT_PARITY_EN
  logic             parity_reg;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      data_reg   <= '0;
      cnt_reg    <= '0;
`ifdef PISO_READOUT_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // LOAD_READY is high exactly in IDLE, so LOAD_VALID alone is the accept.
          if (LOAD_VALID) begin
            data_reg   <= DATA_IN;
            cnt_reg    <= CNT_W'(WIDTH - 1);
`ifdef PISO_READOUT_PARITY_EN
            parity_reg <= ^DATA_IN;
`endif
            state_reg  <= SHIFT;
          end
        end

        SHIFT: begin
          if (SHIFT_EN) begin
            data_reg <= {data_reg[WIDTH-2:0], 1'b0};
            if (cnt_reg == '0) begin
`ifdef PISO_READOUT_PARITY_EN
              state_reg <= PAR;
`else
              state_reg <= FIN;
`endif
            end else begin
              // Counter stops at zero; the transition above leaves SHIFT instead.
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end

        PAR: begin
`ifdef PISO_READOUT_PARITY_EN
          if (SHIFT_EN) begin
            state_reg <= FIN;
          end
`else
          // Unreachable without the parity option; recover to IDLE.
          state_reg <= IDLE;
`endif
        end

        FIN: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  assign LOAD_READY = (state_reg == IDLE);
  assign DONE       = (state_reg == FIN);

`ifdef PISO_READOUT_PARITY_EN
  assign SHIFT_VALID = (state_reg == SHIFT) || (state_reg == PAR);
  assign SHIFT_OUT   = ((state_reg == SHIFT) && data_reg[WIDTH-1]) ||
                       ((state_reg == PAR)   && parity_reg);
`else
  assign SHIFT_VALID = (state_reg == SHIFT);
  assign SHIFT_OUT   = (state_reg == SHIFT) && data_reg[WIDTH-1];
`endif

endmodule
